// File: rtl/audio_pkg.sv
// Shared audio-path definitions: run-state encoding, counter width helper and
// default frame geometry common to the serializer and the receive-side deserializer.
package audio_pkg;

  localparam int DEFAULT_WIDTH    = 16;
  localparam int DEFAULT_CHANNELS = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pcm_frame_timer.sv
// Frame timing for the PCM transmitter: bit and slot counters, frame_sync,
// ch_idx and the last-bit strobe that marks the upcoming frame boundary.
module pcm_frame_timer
  import audio_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CHANNELS = DEFAULT_CHANNELS
) (
  input  logic                                bclk,
  input  logic                                reset,
  input  logic                                load,
  input  logic                                step,
  input  logic                                clear,
  output logic                                last_bit,
  output logic                                frame_sync,
  output logic [clog2_min1(CHANNELS)-1:0]     ch_idx
);

  localparam int BIT_W  = clog2_min1(WIDTH);
  localparam int SLOT_W = clog2_min1(CHANNELS);

  logic [BIT_W-1:0]  bit_cnt;
  logic [SLOT_W-1:0] slot_cnt;

  assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1)) && (slot_cnt == SLOT_W'(CHANNELS - 1));
  assign ch_idx   = slot_cnt;

  // Counters always describe the bit currently on d_out.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      frame_sync <= 1'b0;
    end else if (load) begin
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      frame_sync <= 1'b1;
    end else if (step) begin
      frame_sync <= 1'b0;
      if (bit_cnt == BIT_W'(WIDTH - 1)) begin
        bit_cnt  <= '0;
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end else begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
    end else if (clear) begin
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      frame_sync <= 1'b0;
    end
  end

endmodule

// File: rtl/pcm_serializer_tx.sv
// Multi-channel PCM serial transmitter: one-deep frame buffer, transmit shifter and
// IDLE/RUN control. Optional macro PCM_SERIALIZER_TX_HOLD_LAST_EN repeats the last frame on underrun.
module pcm_serializer_tx
  import audio_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int CHANNELS  = DEFAULT_CHANNELS,
  parameter int MSB_FIRST = 1
) (
  input  logic                                bclk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [CHANNELS*WIDTH-1:0]           data,
  input  logic                                data_valid,
  output logic                                data_ready,
  output logic                                d_out,
  output logic                                frame_sync,
  output logic [clog2_min1(CHANNELS)-1:0]     ch_idx,
  output logic                                underrun
);

  localparam int FRAME_BITS = CHANNELS * WIDTH;

  // Handshake: a frame transfers on any rising bclk where data_valid && data_ready.
  // data_ready is high exactly while the holding buffer is empty; a full buffer ignores data_valid.

  state_t state, state_nxt;
  logic   load, step, clear, last_bit;

  logic [FRAME_BITS-1:0] buf_data;
  logic [FRAME_BITS-1:0] shifter;
  logic [FRAME_BITS-1:0] empty_fill;
  logic [FRAME_BITS-1:0] load_frame;
  logic [FRAME_BITS-1:0] ordered;

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The frame in progress always completes; enable only matters at a boundary.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!last_bit) begin
          step = 1'b1;
        end else if (enable) begin
          load = 1'b1;
        end else begin
          clear     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PCM_SERIALIZER_TX_HOLD_LAST_EN
  logic [FRAME_BITS-1:0] last_frame;

  always_ff @(posedge bclk or posedge reset) begin
    if (reset)                    last_frame <= '0;
    else if (load && !data_ready) last_frame <= buf_data;
  end

  assign empty_fill = last_frame;
`else
  assign empty_fill = '0;
`endif

  // No bypass: an empty buffer at load time always yields the fill frame.
  assign load_frame = data_ready ? empty_fill : buf_data;

  // Reorder the frame into transmit order so the shifter only ever shifts right.
  always_comb begin
    ordered = '0;
    for (int s = 0; s < CHANNELS; s++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (MSB_FIRST != 0) ordered[s*WIDTH + b] = load_frame[s*WIDTH + WIDTH - 1 - b];
        else                ordered[s*WIDTH + b] = load_frame[s*WIDTH + b];
      end
    end
  end

  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      data_ready <= 1'b1;
      buf_data   <= '0;
      shifter    <= '0;
      d_out      <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= load && data_ready;
      if (data_valid && data_ready) begin
        buf_data   <= data;
        data_ready <= 1'b0;
      end else if (load) begin
        data_ready <= 1'b1;
      end
      if (load) begin
        shifter <= ordered >> 1;
        d_out   <= ordered[0];
      end else if (step) begin
        shifter <= shifter >> 1;
        d_out   <= shifter[0];
      end else if (clear) begin
        shifter <= '0;
        d_out   <= 1'b0;
      end
    end
  end

  pcm_frame_timer #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_timer (
    .bclk       (bclk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .clear      (clear),
    .last_bit   (last_bit),
    .frame_sync (frame_sync),
    .ch_idx     (ch_idx)
  );

endmodule

// File: tb/tb_pcm_serializer_tx.sv
// Bench for pcm_serializer_tx: MSB-first and LSB-first instances share stimulus and
// are compared each cycle against a frame-position model of the serial stream.
module tb_pcm_serializer_tx;

  localparam int W  = 16;
  localparam int C  = 2;
  localparam int FB = W * C;

  logic          bclk = 1'b0;
  logic          reset;
  logic          enable;
  logic          data_valid;
  logic [FB-1:0] data;

  logic data_ready_m, d_out_m, frame_sync_m, ch_idx_m, underrun_m;
  logic data_ready_l, d_out_l, frame_sync_l, ch_idx_l, underrun_l;

  always #5 bclk = ~bclk;

  pcm_serializer_tx #(.WIDTH(W), .CHANNELS(C), .MSB_FIRST(1)) dut_msb (
    .bclk       (bclk),
    .reset      (reset),
    .enable     (enable),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready_m),
    .d_out      (d_out_m),
    .frame_sync (frame_sync_m),
    .ch_idx     (ch_idx_m),
    .underrun   (underrun_m)
  );

  pcm_serializer_tx #(.WIDTH(W), .CHANNELS(C), .MSB_FIRST(0)) dut_lsb (
    .bclk       (bclk),
    .reset      (reset),
    .enable     (enable),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready_l),
    .d_out      (d_out_l),
    .frame_sync (frame_sync_l),
    .ch_idx     (ch_idx_l),
    .underrun   (underrun_l)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: position within the serial frame plus a one-entry buffer queue.
  bit            m_run;
  int            m_pos;
  bit            m_und;
  int            m_xfers;
  logic [FB-1:0] m_cur;
  logic [FB-1:0] m_last;
  logic [FB-1:0] m_buf_q[$];
  logic [31:0]   exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_bit(input bit msb);
    int s;
    int b;
    if (!m_run) return 1'b0;
    s = m_pos / W;
    b = m_pos % W;
    return msb ? m_cur[s*W + W - 1 - b] : m_cur[s*W + b];
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_pos  = 0;
    m_und  = 1'b0;
    m_cur  = '0;
    m_last = '0;
    m_buf_q.delete();
  endtask

  task automatic model_edge();
    bit xfer;
    bit do_load;
    xfer    = data_valid && (m_buf_q.size() == 0);
    do_load = 1'b0;
    m_und   = 1'b0;
    if (!m_run) begin
      do_load = enable;
    end else if (m_pos == FB - 1) begin
      if (enable) do_load = 1'b1;
      else begin
        m_run = 1'b0;
        m_pos = 0;
      end
    end else begin
      m_pos++;
    end
    if (do_load) begin
      m_run = 1'b1;
      m_pos = 0;
      if (m_buf_q.size() > 0) begin
        m_cur  = m_buf_q.pop_front();
        m_last = m_cur;
      end else begin
        m_und = 1'b1;
`ifdef PCM_SERIALIZER_TX_HOLD_LAST_EN
        m_cur = m_last;
`else
        m_cur = '0;
`endif
      end
    end
    if (xfer) begin
      m_buf_q.push_back(data);
      m_xfers++;
    end
  endtask

  task automatic check_outputs();
    check("d_out_msb",      32'(d_out_m),      32'(model_bit(1'b1)));
    check("d_out_lsb",      32'(d_out_l),      32'(model_bit(1'b0)));
    check("frame_sync",     32'(frame_sync_m), 32'(m_run && m_pos == 0));
    check("frame_sync_lsb", 32'(frame_sync_l), 32'(m_run && m_pos == 0));
    check("ch_idx",         32'(ch_idx_m),     m_run ? 32'(m_pos / W) : 32'd0);
    check("ch_idx_lsb",     32'(ch_idx_l),     m_run ? 32'(m_pos / W) : 32'd0);
    check("underrun",       32'(underrun_m),   32'(m_und));
    check("underrun_lsb",   32'(underrun_l),   32'(m_und));
    check("data_ready",     32'(data_ready_m), 32'(m_buf_q.size() == 0));
    check("data_ready_lsb", 32'(data_ready_l), 32'(m_buf_q.size() == 0));
  endtask

  // Inputs change only after the negedge check, so they are stable at each posedge.
  task automatic tick();
    @(posedge bclk);
    model_edge();
    @(negedge bclk);
    check_outputs();
  endtask

  task automatic capture_frame(input int drop_enable_at, output logic [31:0] cap_m,
                               output logic [31:0] cap_l);
    cap_m = '0;
    cap_l = '0;
    for (int i = 0; i < FB; i++) begin
      cap_m = {cap_m[30:0], d_out_m};
      cap_l = {cap_l[30:0], d_out_l};
      if (i == drop_enable_at) enable = 1'b0;
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] cap_m;
    logic [31:0] cap_l;
    int          waited;

    reset      = 1'b1;
    enable     = 1'b0;
    data_valid = 1'b0;
    data       = '0;
    m_xfers    = 0;
    model_reset();
    repeat (2) @(negedge bclk);
    check_outputs();
    reset = 1'b0;
    tick();

    // Known frame, MSB-first and LSB-first orderings, then an underrun frame.
    data       = 32'h8001_A5C3;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    data       = '0;
    enable     = 1'b1;
    tick();
    capture_frame(-1, cap_m, cap_l);
    exp_q.push_back(32'hA5C3_8001);
    exp_q.push_back(32'hC3A5_8001);
    check("frame1_msb", cap_m, exp_q.pop_front());
    check("frame1_lsb", cap_l, exp_q.pop_front());

    // Second frame has no refill; enable drops at bit 5 but the frame completes.
    capture_frame(5, cap_m, cap_l);
`ifdef PCM_SERIALIZER_TX_HOLD_LAST_EN
    exp_q.push_back(32'hA5C3_8001);
    exp_q.push_back(32'hC3A5_8001);
`else
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
`endif
    check("frame2_msb", cap_m, exp_q.pop_front());
    check("frame2_lsb", cap_l, exp_q.pop_front());
    repeat (4) tick();

    // Continuous data_valid: one transfer per frame in steady state.
    data_valid = 1'b1;
    data       = $urandom;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 3 * FB; i++) begin
      data = $urandom;
      tick();
    end
    waited = 0;
    while (!(m_run && m_pos == 0) && waited < 4 * FB) begin
      data = $urandom;
      tick();
      waited++;
    end
    check("align_frame_start", 32'(m_run && m_pos == 0), 32'd1);
    m_xfers = 0;
    for (int i = 0; i < 5 * FB; i++) begin
      data = $urandom;
      tick();
    end
    check("xfers_per_5_frames", 32'(m_xfers), 32'd5);

    // Asynchronous reset at bit 10 of a frame.
    waited = 0;
    while (!(m_run && m_pos == 10) && waited < 4 * FB) begin
      data = $urandom;
      tick();
      waited++;
    end
    check("reach_bit10", 32'(m_run && m_pos == 10), 32'd1);
    #1 reset = 1'b1;
    model_reset();
    #1 check_outputs();
    data_valid = 1'b0;
    @(negedge bclk);
    check_outputs();
    reset = 1'b0;
    tick();
    check("restart_frame_sync", 32'(frame_sync_m), 32'd1);
    repeat (40) tick();

    // Random traffic with occasional enable toggles.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      data_valid = ($urandom_range(0, 3) != 0);
      data       = $urandom;
      tick();
    end
    enable = 1'b0;
    repeat (2 * FB + 4) tick();
    check("final_idle_d_out", 32'(d_out_m), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
